// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the CPU pipeline slice. The pipeline stage register FSM
// encoding lives here so stage wrappers and debug logic can decode it.
//   pstage_t : EMPTY (nothing held), FULL (main register valid),
//              SKIDF (main and skid registers both valid)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } pstage_t;

endpackage : cpu_types_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones maximum instead of wrapping.
// Ports:
//   CLK   in  1     clock
//   nRST  in  1     async active-low reset (clears the count)
//   inc   in  1     increment request for this cycle
//   count out CNTW  current count, saturates at 2^CNTW-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (inc && (count_q != {CNTW{1'b1}})) begin
            count_d = count_q + CNTW'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline register used between CPU stages (ID/EX, EX/MEM,
// MEM/WB). The stage bundle is packed into in_data. With SKID=1 a second
// (skid) entry lets in_ready be a pure flop output; with SKID=0 a single
// entry is kept and in_ready is passed back combinationally.
// A HALT-tagged entry leaving the stage sets the sticky 'halted' flag,
// after which the stage neither accepts nor presents entries until reset.
// Ports:
//   CLK, nRST              clock, async active-low reset
//   in_valid/in_ready      upstream handshake; in_data, in_halt payload
//   out_valid/out_ready    downstream handshake; out_data, out_halt payload
//   flush                  synchronous squash of all held entries
//   halted                 sticky: HALT entry has been issued
//   stall_cnt              saturating count of out_valid & ~out_ready cycles
//   bubble_cnt             saturating count of ~out_valid & ~halted cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    input  logic             flush,
    output logic             halted,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  bubble_cnt
);

    localparam bit SKID_EN = (SKID != 0);

    pstage_t          state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_halt_q, main_halt_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_halt_q, skid_halt_d;
    logic             halted_q, halted_d;

    logic accept;
    logic issue;
    logic halt_issue;

    assign accept     = in_valid & in_ready;
    assign issue      = out_valid & out_ready;
    assign halt_issue = issue & main_halt_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush || halt_issue) begin
            // Anything queued behind a departing HALT is dead.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL: begin
                    if (issue && !accept) begin
                        state_d = EMPTY;
                    end else if (accept && !issue && SKID_EN) begin
                        state_d = SKIDF;
                    end
                end
                SKIDF: if (issue) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == FULL) || (state_q == SKIDF);
        out_data  = main_data_q;
        out_halt  = main_halt_q;
        halted    = halted_q;
        // nRST gating keeps in_ready low for the whole time reset is held.
        if (SKID_EN) begin
            in_ready = (state_q != SKIDF) && !halted_q && nRST;
        end else begin
            in_ready = (!out_valid || out_ready) && !halted_q && nRST;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: main / skid entry registers and the sticky halt flag
    // ------------------------------------------------------------------
    always_comb begin
        main_data_d = main_data_q;
        main_halt_d = main_halt_q;
        skid_data_d = skid_data_q;
        skid_halt_d = skid_halt_q;
        halted_d    = halted_q | halt_issue;

        if (flush || halt_issue) begin
            main_data_d = '0;
            main_halt_d = 1'b0;
            skid_data_d = '0;
            skid_halt_d = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = in_data;
                        main_halt_d = in_halt;
                    end
                end
                FULL: begin
                    if (accept && issue) begin
                        main_data_d = in_data;
                        main_halt_d = in_halt;
                    end else if (accept && SKID_EN) begin
                        // Downstream stalled: park the newcomer behind main.
                        skid_data_d = in_data;
                        skid_halt_d = in_halt;
                    end
                end
                SKIDF: begin
                    if (issue) begin
                        main_data_d = skid_data_q;
                        main_halt_d = skid_halt_q;
                        skid_data_d = '0;
                        skid_halt_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the payload registers are reset as well, so out_data and
            // out_halt read a defined zero straight out of reset.
            main_data_q <= '0;
            main_halt_q <= 1'b0;
            skid_data_q <= '0;
            skid_halt_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_halt_q <= main_halt_d;
            skid_data_q <= skid_data_d;
            skid_halt_q <= skid_halt_d;
            halted_q    <= halted_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (not affected by flush)
    // ------------------------------------------------------------------
    sat_counter #(.CNTW(CNTW)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_bubble_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (~out_valid & ~halted_q),
        .count (bubble_cnt)
    );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg: a SKID=1 instance (main), a SKID=0
// instance (z_*) and a SKID=1/CNTW=4 instance (w_*). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    // SKID=1, default widths
    logic        in_valid, in_ready, in_halt;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_halt;
    logic [31:0] out_data;
    logic        flush, halted;
    logic [15:0] stall_cnt, bubble_cnt;

    // SKID=0
    logic        z_in_valid, z_in_ready, z_in_halt;
    logic [31:0] z_in_data;
    logic        z_out_valid, z_out_ready, z_out_halt;
    logic [31:0] z_out_data;
    logic        z_flush, z_halted;
    logic [15:0] z_stall_cnt, z_bubble_cnt;

    // SKID=1, CNTW=4
    logic        w_in_valid, w_in_ready, w_in_halt;
    logic [31:0] w_in_data;
    logic        w_out_valid, w_out_ready, w_out_halt;
    logic [31:0] w_out_data;
    logic        w_flush, w_halted;
    logic [3:0]  w_stall_cnt, w_bubble_cnt;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNTW(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
        .flush(flush), .halted(halted), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNTW(16)) dut0 (
        .CLK(CLK), .nRST(nRST),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_halt(z_in_halt),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_halt(z_out_halt),
        .flush(z_flush), .halted(z_halted), .stall_cnt(z_stall_cnt), .bubble_cnt(z_bubble_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNTW(4)) dut4 (
        .CLK(CLK), .nRST(nRST),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_halt(w_in_halt),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_halt(w_out_halt),
        .flush(w_flush), .halted(w_halted), .stall_cnt(w_stall_cnt), .bubble_cnt(w_bubble_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboards hold {halt, data} in acceptance order.
    logic [32:0] sb1[$];
    logic [32:0] sb0[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score handshakes on the falling edge, then step past
    // the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        logic [32:0] exp;
        logic        issue1;
        @(negedge CLK);
        issue1 = out_valid && out_ready;
        if (issue1) begin
            n_cmp++;
            assert (sb1.size() != 0) else begin
                n_err++;
                $error("FAIL sb1_underflow: observed 0x%0h expected empty scoreboard hit", out_data);
            end
            if (sb1.size() != 0) begin
                exp = sb1.pop_front();
                check("sb1_entry", {31'd0, out_halt, out_data}, {31'd0, exp});
            end
            if (out_halt) sb1.delete();
        end
        if (flush) begin
            sb1.delete();
        end else if (in_valid && in_ready && !(issue1 && out_halt)) begin
            sb1.push_back({in_halt, in_data});
        end

        if (z_out_valid && z_out_ready) begin
            n_cmp++;
            assert (sb0.size() != 0) else begin
                n_err++;
                $error("FAIL sb0_underflow: observed 0x%0h expected empty scoreboard hit", z_out_data);
            end
            if (sb0.size() != 0) begin
                exp = sb0.pop_front();
                check("sb0_entry", {31'd0, z_out_halt, z_out_data}, {31'd0, exp});
            end
        end
        if (z_in_valid && z_in_ready) sb0.push_back({z_in_halt, z_in_data});

        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] s0;
    logic [15:0] b0;

    initial begin
        nRST = 1'b0;
        in_valid = 0; in_data = '0; in_halt = 0; out_ready = 0; flush = 0;
        z_in_valid = 0; z_in_data = '0; z_in_halt = 0; z_out_ready = 0; z_flush = 0;
        w_in_valid = 0; w_in_data = '0; w_in_halt = 0; w_out_ready = 0; w_flush = 0;

        // ---- reset state ----
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_z_in_ready", z_in_ready, 0);
        check("rst_halted", halted, 0);
        check("rst_out_halt", out_halt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        #19 nRST = 1'b1;
        @(posedge CLK); #1;
        check("ready_after_rst", in_ready, 1);

        // ---- single pass-through ----
        in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 1;
        cycle();
        in_valid = 0;
        check("pt_out_valid_c1", out_valid, 1);
        check("pt_out_data_c1", out_data, 32'hDEADBEEF);
        cycle();
        check("pt_empty_c2", out_valid, 0);

        // ---- skid fill, then drain in order ----
        out_ready = 0; s0 = stall_cnt;
        in_valid = 1; in_data = 32'd1;
        cycle();
        in_data = 32'd2;
        check("skid_ready_full", in_ready, 1);
        cycle();
        in_valid = 0;
        check("skid_ready_skidf", in_ready, 0);
        cycle();
        check("skid_stall_cnt", stall_cnt, s0 + 16'd2);
        check("skid_still_ready0", in_ready, 0);
        out_ready = 1;
        check("skid_head_a", out_data, 32'd1);
        cycle();
        check("skid_head_b_valid", out_valid, 1);
        check("skid_head_b", out_data, 32'd2);
        cycle();
        check("skid_drained", out_valid, 0);

        // ---- flush while in SKIDF with C offered ----
        out_ready = 0; in_valid = 1; in_data = 32'd4;
        cycle();
        in_data = 32'd5;
        cycle();
        check("flush_pre_ready", in_ready, 0);
        in_data = 32'd3; flush = 1;
        cycle();
        flush = 0; in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        check("flush_halted", halted, 0);
        check("flush_ready", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush_no_c", out_valid, 0);
        end

        // ---- async reset mid-stream in FULL ----
        out_ready = 0; in_valid = 1; in_data = 32'd9;
        cycle();
        in_valid = 0;
        check("pre_rst_full", out_valid, 1);
        #2 nRST = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_stall", stall_cnt, 0);
        check("arst_bubble", bubble_cnt, 0);
        sb1.delete(); sb0.delete();
        #3 nRST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_empty", out_valid, 0);

        // ---- CNTW=4 saturation ----
        w_in_valid = 1; w_in_data = 32'h55; w_out_ready = 0;
        cycle();
        w_in_valid = 0;
        repeat (20) cycle();
        check("sat_stall_15", w_stall_cnt, 4'd15);
        check("sat_out_data", w_out_data, 32'h55);

        // ---- SKID=0 combinational ready ----
        z_out_ready = 0; z_in_valid = 1; z_in_data = 32'd11;
        cycle();
        z_out_ready = 1; #1;
        check("comb_ready_1a", z_in_ready, 1);
        z_out_ready = 0; #1;
        check("comb_ready_0", z_in_ready, 0);
        z_out_ready = 1; #1;
        check("comb_ready_1b", z_in_ready, 1);
        z_in_data = 32'd12;
        cycle();

        for (int i = 0; i < 100; i++) begin
            z_in_valid  = 1'($urandom_range(0, 1));
            z_out_ready = 1'($urandom_range(0, 1));
            z_in_data   = $urandom;
            cycle();
        end
        z_in_valid = 0; z_out_ready = 1;
        repeat (3) cycle();
        check("sb0_drained", sb0.size(), 0);
        check("z_empty", z_out_valid, 0);

        // ---- HALT ordering and stickiness ----
        out_ready = 0; in_valid = 1; in_halt = 0; in_data = 32'd6;
        cycle();
        in_halt = 1; in_data = 32'd7;
        cycle();
        in_valid = 0; in_halt = 0;
        out_ready = 1;
        check("halt_older_first", out_data, 32'd6);
        check("halt_older_tag", out_halt, 0);
        cycle();
        check("halt_head_tag", out_halt, 1);
        check("halt_head_data", out_data, 32'd7);
        check("halt_not_yet", halted, 0);
        cycle();
        check("halted_set", halted, 1);
        check("halted_in_ready", in_ready, 0);
        check("halted_out_valid", out_valid, 0);
        b0 = bubble_cnt;
        flush = 1;
        cycle();
        flush = 0;
        check("halted_after_flush", halted, 1);
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'd100 + 32'(i);
            check("halted_ready_loop", in_ready, 0);
            cycle();
            check("halted_valid_loop", out_valid, 0);
        end
        in_valid = 0;
        check("halted_final", halted, 1);
        check("halted_no_bubble", bubble_cnt, b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_reg
